// File: rtl/uart_vpp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_vpp_scheduler                                     |
// | Description : Round-robin scheduler time-sharing one UART_MASTER_VPP |
// |               link between NCH requesters. It gates send_enable so   |
// |               one frame starts per grant attempt, tracks completion, |
// |               and retries on failure or timeout.                     |
// | Options     : UART_VPP_SCHED_PRIO_EN - channel 0 has fixed priority  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_vpp_scheduler #(
  parameter int NCH       = 4,
  parameter int NBIT_OUT  = 10,
  parameter int NBIT_IN   = 10,
  parameter int MAX_RETRY = 2,
  parameter int TMO_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    t128ms_tick,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*NBIT_OUT-1:0] tx_data,
  output logic [NCH-1:0]          ack,
  output logic [NCH*NBIT_IN-1:0]  rx_data,
  output logic [NCH-1:0]          rx_err,
  output logic                    m_send_enable,
  output logic [NBIT_OUT-1:0]     m_par_data_in,
  input  logic                    m_read_flag,
  input  logic                    m_ser_data_in,
  input  logic                    m_error_flag,
  input  logic [NBIT_IN-1:0]      m_par_data_out,
  output logic [2:0]              cur_ch,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_RX   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] c_max_retry = 3'(MAX_RETRY);
  localparam logic [3:0] c_tmo_ticks = 4'(TMO_TICKS);
  localparam logic [2:0] c_last_ch   = 3'(NCH - 1);
  localparam logic [3:0] c_nch       = 4'(NCH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_cur_ch;
  logic [2:0]           r_rr;
  logic [2:0]           r_retry;
  logic [3:0]           r_tmo;
  logic                 r_err_base;
  logic                 r_rx_seen;
  logic                 r_tmo_fail;
  logic                 r_read_d;
  logic [NBIT_OUT-1:0]  r_tx;
  logic [NBIT_IN-1:0]   r_rx_mem [NCH];
  logic [NCH-1:0]       r_rx_err;

  logic                 w_any_req;
  logic [NCH-1:0]       w_req_rot;
  logic                 w_found;
  logic [2:0]           w_off;
  logic [3:0]           w_sum;
  logic [2:0]           w_grant;
  logic [NBIT_OUT-1:0]  w_tx_sel;
  logic [2:0]           w_rr_nxt;
  logic                 w_fall;
  logic                 w_tmo_hit;
  logic                 w_success;
  logic                 w_retry_ok;

  // Round-robin grant: first requester at or after the rr pointer, plus tx word mux
  always_comb begin
    w_any_req = |req;
    w_req_rot = NCH'({req, req} >> r_rr);
    w_found   = 1'b0;
    w_off     = 3'd0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found = 1'b1;
        w_off   = 3'(k);
      end
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_off};
    if (w_sum >= c_nch) w_grant = 3'(w_sum - c_nch);
    else                w_grant = w_sum[2:0];
`ifdef UART_VPP_SCHED_PRIO_EN
    if (req[0]) w_grant = 3'd0;
`endif
    w_tx_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == 3'(i)) w_tx_sel = tx_data[i*NBIT_OUT +: NBIT_OUT];
    end
  end

  // Exchange status terms; a read_flag fall takes precedence over a same-cycle tick
  always_comb begin
    w_fall     = r_read_d & ~m_read_flag;
    w_tmo_hit  = (r_state == S_RUN) && !w_fall && t128ms_tick &&
                 ((r_tmo + 4'd1) >= c_tmo_ticks);
    w_success  = r_rx_seen && !(m_error_flag && !r_err_base) && !r_tmo_fail;
    w_retry_ok = (r_retry < c_max_retry);
    w_rr_nxt   = (r_cur_ch == c_last_ch) ? 3'd0 : (r_cur_ch + 3'd1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_state_nxt = S_ARM;
      S_ARM:  if (t128ms_tick) w_state_nxt = S_RUN;
      S_RUN:  if (w_fall || w_tmo_hit) w_state_nxt = S_RX;
      S_RX: begin
        if (w_success)       w_state_nxt = S_DONE;
        else if (w_retry_ok) w_state_nxt = S_ARM;
        else                 w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Previous read_flag for fall detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_read_d <= 1'b0;
    else        r_read_d <= m_read_flag;
  end

  // Transaction datapath: grant latch, per-attempt tracking, result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_ch   <= 3'd0;
      r_rr       <= 3'd0;
      r_retry    <= 3'd0;
      r_tmo      <= 4'd0;
      r_err_base <= 1'b0;
      r_rx_seen  <= 1'b0;
      r_tmo_fail <= 1'b0;
      r_tx       <= '0;
      r_rx_err   <= '0;
      for (int i = 0; i < NCH; i++) r_rx_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_cur_ch <= w_grant;
            r_tx     <= w_tx_sel;
            r_retry  <= 3'd0;
          end
        end
        S_ARM: begin
          if (t128ms_tick) begin
            r_tmo      <= 4'd0;
            r_err_base <= m_error_flag;
            r_rx_seen  <= 1'b0;
            r_tmo_fail <= 1'b0;
          end
        end
        S_RUN: begin
          if (m_read_flag && !m_ser_data_in) r_rx_seen <= 1'b1;
          if (!w_fall && t128ms_tick)        r_tmo     <= r_tmo + 4'd1;
          if (w_tmo_hit)                     r_tmo_fail <= 1'b1;
        end
        S_RX: begin
          for (int i = 0; i < NCH; i++) begin
            if (r_cur_ch == 3'(i)) begin
              if (w_success) begin
                r_rx_mem[i] <= m_par_data_out;
                r_rx_err[i] <= 1'b0;
              end else if (!w_retry_ok) begin
                r_rx_err[i] <= 1'b1;
              end
            end
          end
          if (!w_success && w_retry_ok) r_retry <= r_retry + 3'd1;
        end
        S_DONE: begin
`ifdef UART_VPP_SCHED_PRIO_EN
          if (r_cur_ch != 3'd0) r_rr <= w_rr_nxt;
`else
          r_rr <= w_rr_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

  // One-cycle completion pulse to the owning channel
  always_comb begin
    ack = '0;
    if (r_state == S_DONE) begin
      for (int i = 0; i < NCH; i++) begin
        if (r_cur_ch == 3'(i)) ack[i] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
    assign rx_data[gi*NBIT_IN +: NBIT_IN] = r_rx_mem[gi];
  end

  assign rx_err        = r_rx_err;
  assign m_send_enable = (r_state == S_ARM);
  assign m_par_data_in = r_tx;
  assign cur_ch        = r_cur_ch;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_vpp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_vpp_scheduler                                  |
// | Description : Scoreboard bench for uart_vpp_scheduler with a simple  |
// |               behavioural model of the UART master and slave.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_vpp_scheduler;

  localparam int NCH      = 4;
  localparam int NBO      = 10;
  localparam int NBI      = 10;
  localparam int TICK_PER = 20;
  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_ERR    = 2;
  localparam int M_STUCK  = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick = 1'b0;
  logic [NCH-1:0]     req = '0;
  logic [NCH*NBO-1:0] tx = '0;
  logic [NCH-1:0]     ack;
  logic [NCH*NBI-1:0] rx_data;
  logic [NCH-1:0]     rx_err;
  logic               m_send_enable;
  logic [NBO-1:0]     m_par_data_in;
  logic               rd = 1'b0;
  logic               ser = 1'b1;
  logic               errf = 1'b0;
  logic [NBI-1:0]     pout = '0;
  logic [2:0]         cur_ch;
  logic               busy;

  typedef struct {
    int             ch;
    logic [NBI-1:0] data;
    logic           err;
  } exp_t;

  exp_t           exp_q[$];
  int             checks = 0;
  int             fails  = 0;
  int             mode   = M_NORMAL;
  int             phase  = 0;
  int             frames = 0;
  int             cyc    = 0;
  logic [NBO-1:0] last_tx = '0;

  uart_vpp_scheduler #(
    .NCH(NCH), .NBIT_OUT(NBO), .NBIT_IN(NBI), .MAX_RETRY(2), .TMO_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .t128ms_tick(tick), .req(req), .tx_data(tx),
    .ack(ack), .rx_data(rx_data), .rx_err(rx_err),
    .m_send_enable(m_send_enable), .m_par_data_in(m_par_data_in),
    .m_read_flag(rd), .m_ser_data_in(ser), .m_error_flag(errf),
    .m_par_data_out(pout), .cur_ch(cur_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [NBI-1:0] data, input logic err);
    exp_t e;
    e.ch = ch; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input string name, input int n, input int budget);
    int got = 0;
    int c = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      if (ack != '0) got++;
    end
    if (got < n) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got %0d acks expected %0d", name, got, n);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_cur_ch"}, 32'(cur_ch), 0);
    chk({tag, "_send_en"}, 32'(m_send_enable), 0);
    chk({tag, "_par_in"}, 32'(m_par_data_in), 0);
    chk({tag, "_rx_data"}, 32'(rx_data), 0);
    chk({tag, "_rx_err"}, 32'(rx_err), 0);
  endtask

  // Tick generator plus UART master/slave model; frames start on tick with send_enable
  initial begin : env
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        phase = 0; tick = 1'b0; rd = 1'b0; ser = 1'b1;
        continue;
      end
      tick = (cyc % TICK_PER == 0);
      if (phase != 0) begin
        phase++;
        case (phase)
          2: chk("send_en_low_in_run", 32'(m_send_enable), 0);
          3: begin
            rd = 1'b1;
            if (mode != M_SILENT) ser = 1'b0;
            if (mode == M_STUCK) phase = 0;
          end
          4: ser = 1'b1;
          5: if (mode == M_ERR) errf = 1'b1;
          6: pout = m_par_data_in ^ 10'h3FF;
          7: begin rd = 1'b0; phase = 0; end
          default: ;
        endcase
      end else begin
        ser = 1'b1;
        if (mode != M_STUCK) rd = 1'b0;
        if (mode == M_NORMAL) errf = 1'b0;
      end
      if (tick && m_send_enable) begin
        frames++;
        last_tx = m_par_data_in;
        phase = 1;
      end
    end
  end

  // Scoreboard monitor: every ack pops one expected completion
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          e = exp_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1 << e.ch));
          chk("rx_data", 32'(rx_data[e.ch*NBI +: NBI]), 32'(e.data));
          chk("rx_err", 32'(rx_err[e.ch]), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int f0;
    int c;
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All channels requesting, held through five completions
    tx[0*NBO +: NBO] = 10'h011;
    tx[1*NBO +: NBO] = 10'h022;
    tx[2*NBO +: NBO] = 10'h033;
    tx[3*NBO +: NBO] = 10'h044;
`ifdef UART_VPP_SCHED_PRIO_EN
    for (int i = 0; i < 5; i++) push(0, 10'h3EE, 1'b0);
`else
    push(0, 10'h3EE, 1'b0);
    push(1, 10'h3DD, 1'b0);
    push(2, 10'h3CC, 1'b0);
    push(3, 10'h3BB, 1'b0);
    push(0, 10'h3EE, 1'b0);
`endif
    req = 4'b1111;
    wait_acks("rr", 5, 800);
    req = '0;
    repeat (3) @(negedge clk);

    // Single request on channel 2
    tx[2*NBO +: NBO] = 10'h155;
    f0 = frames;
    push(2, 10'h2AA, 1'b0);
    req = 4'b0100;
    wait_acks("single", 1, 200);
    req = '0;
    chk("single_frames", 32'(frames - f0), 1);
    chk("single_tx_word", 32'(last_tx), 32'h155);
    repeat (3) @(negedge clk);

    // Silent slave: three frames then failure, data kept
    mode = M_SILENT;
    f0 = frames;
    push(2, 10'h2AA, 1'b1);
    req = 4'b0100;
    wait_acks("silent", 1, 400);
    req = '0;
    mode = M_NORMAL;
    chk("silent_frames", 32'(frames - f0), 3);
    repeat (3) @(negedge clk);

    // Error flag rises in first attempt; second attempt succeeds
    tx[2*NBO +: NBO] = 10'h30F;
    mode = M_ERR;
    f0 = frames;
    push(2, 10'h0F0, 1'b0);
    req = 4'b0100;
    wait_acks("errflag", 1, 400);
    req = '0;
    mode = M_NORMAL;
    chk("errflag_frames", 32'(frames - f0), 2);
    repeat (3) @(negedge clk);

    // Master stuck busy: every attempt times out
    tx[2*NBO +: NBO] = 10'h100;
    mode = M_STUCK;
    f0 = frames;
    push(2, 10'h0F0, 1'b1);
    req = 4'b0100;
    wait_acks("stuck", 1, 800);
    req = '0;
    mode = M_NORMAL;
    chk("stuck_frames", 32'(frames - f0), 3);
    repeat (3) @(negedge clk);

    // Reset mid-exchange, then normal grant after release
    tx[1*NBO +: NBO] = 10'h1AB;
    req = 4'b0010;
    c = 0;
    while (phase != 4 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (phase != 4) begin
      checks++;
      fails++;
      $display("FAIL reach_run_timeout: got phase %0d expected 4", phase);
    end
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(1, 10'h254, 1'b0);
    wait_acks("post_reset", 1, 200);
    req = '0;
    repeat (5) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_vpp_scheduler.md
Name: uart_vpp_scheduler

Overview:
Time-shares one UART_MASTER_VPP serial link between NCH requesters (e.g. per-slot VPP/backplane controllers). It round-robin arbitrates request lines and muxes the selected channel's transmit word onto the master. It gates the master's send_enable so exactly one frame starts on the next t128ms_tick. It then tracks the exchange to completion and returns the response word plus status to the owning channel, with bounded retries and timeout.

Parameters:
NCH, 4, number of requesting channels (2..8)
NBIT_OUT, 10, transmit payload width per channel
NBIT_IN, 10, receive payload width per channel
MAX_RETRY, 2, retries after a failed exchange before reporting failure (0..7)
TMO_TICKS, 4, t128ms_tick periods allowed from frame start to completion (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
t128ms_tick  in  1  one-cycle frame-slot pulse, shared with master
req  in  NCH  per-channel request level; held until ack
tx_data  in  NCH*NBIT_OUT  channel i word at [i*NBIT_OUT +: NBIT_OUT]
ack  out  NCH  one-cycle completion pulse for channel i
rx_data  out  NCH*NBIT_IN  last good response per channel, same packing
rx_err  out  NCH  status qualified by ack: 1 = failed after retries
m_send_enable  out  1  to master send_enable
m_par_data_in  out  NBIT_OUT  to master par_data_in
m_read_flag  in  1  from master read_flag
m_ser_data_in  in  1  serial line as seen by master
m_error_flag  in  1  from master error_flag (sticky level)
m_par_data_out  in  NBIT_IN  from master par_data_out
cur_ch  out  3  channel currently owning the link
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: ack=0, rx_data=0, rx_err=0, m_send_enable=0, m_par_data_in=0, cur_ch=0, busy=0, rr pointer=0, retry and timeout counters=0, state=IDLE.
- States: IDLE, ARM, RUN, RX, DONE.
- IDLE: if any req, grant the first requester at or after rr pointer (circular). Latch cur_ch and tx word into m_par_data_in. Clear retry count. Go to ARM next cycle.
- ARM: m_send_enable=1. On t128ms_tick, go to RUN and clear the timeout counter. m_par_data_in stays stable from ARM entry through RUN/RX exit.
- RUN: m_send_enable drops to 0 on entry, so the master cannot restart. Sample m_error_flag into err_base on entry. Record rx_seen=1 if m_read_flag=1 and m_ser_data_in=0 in any cycle. On m_read_flag 1->0 (master back to IDLE), go to RX. Each t128ms_tick increments the timeout counter; reaching TMO_TICKS forces failure.
- RX, one cycle. Success = rx_seen && !(m_error_flag && !err_base).
  - On success: rx_data[cur_ch] <= m_par_data_out, rx_err[cur_ch] <= 0, go to DONE.
  - On failure, with retry < MAX_RETRY: retry++ and go to ARM.
  - On failure otherwise: rx_err[cur_ch] <= 1, rx_data unchanged, go to DONE.
- DONE: ack[cur_ch]=1 for exactly one cycle, rr pointer <= cur_ch+1 mod NCH, go to IDLE. A new grant needs at least one IDLE cycle.
- A req deasserted mid-transaction is ignored; the exchange completes and ack still pulses.
- Simultaneous t128ms_tick and m_read_flag fall in RUN: the fall wins and the tick does not count toward timeout.
- The sticky master error_flag is handled by edge comparison against err_base. If it is already 1, later errors are undetectable; rx_seen still gates success.
- rst_n assertion mid-transaction aborts immediately to the reset values. No ack is issued.

Optional Feature:
UART_VPP_SCHED_PRIO_EN.
- Defined: channel 0 has fixed highest priority. When req[0]=1 in IDLE it is granted regardless of the rr pointer. The rr pointer is not advanced after a channel-0 grant. Other channels rotate as normal.
- Undefined: pure round-robin across all channels.

Test Plan:
- NCH=4, req=4'b0100, tx ch2=10'h155. Master model answers 10'h2AA. Expect m_par_data_in=10'h155 and m_send_enable high until the tick, then rx_data ch2=10'h2AA, ack=4'b0100 for 1 cycle, rx_err[2]=0.
- req=4'b1111 held; each completes in turn. Expect ack order ch0,1,2,3,0 (macro undefined). With UART_VPP_SCHED_PRIO_EN, expect ch0 granted every time.
- Slave silent, m_ser_data_in=1. Expect 1+MAX_RETRY=3 frames started (3 ticks with m_send_enable pre-armed), then ack with rx_err=1 and rx_data unchanged.
- m_error_flag rises 0->1 in the first attempt; the second attempt returns 10'h0F0. Expect 2 frames, rx_data=10'h0F0, rx_err=0.
- Master stuck (m_read_flag held 1). Expect failure after TMO_TICKS=4 ticks per attempt, and ack with rx_err=1 after 3 attempts.
- rst_n pulsed low while in RUN. Expect all outputs at reset values immediately, no ack, and normal grant after release.
